// File: rtl/nasti_mc_pkg.sv
// Shared types and constants for the NASTI memory-controller core-clock stages.
// Holds the transaction field widths, burst/response encodings, the burst
// splitter FSM state type, and the FIFO entry structs exchanged with the
// clock-crossing FIFOs.
package nasti_mc_pkg;

  localparam int unsigned C_NASTI_ID_WIDTH   = 9;
  localparam int unsigned C_NASTI_ADDR_WIDTH = 32;
  localparam int unsigned C_NASTI_DATA_WIDTH = 64;
  localparam int unsigned C_NASTI_USER_WIDTH = 1;
  localparam int unsigned C_NASTI_STRB_WIDTH = C_NASTI_DATA_WIDTH / 8;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {StIdle, StRdBurst, StWrBurst, StWrResp} state_e;

  typedef struct packed {
    logic [C_NASTI_ID_WIDTH-1:0]   ar_id;
    logic [C_NASTI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                    ar_len;
    logic [2:0]                    ar_size;
    logic [1:0]                    ar_burst;
    logic [C_NASTI_USER_WIDTH-1:0] ar_user;
  } ar_trans;

  typedef struct packed {
    logic [C_NASTI_ID_WIDTH-1:0]   aw_id;
    logic [C_NASTI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                    aw_len;
    logic [2:0]                    aw_size;
    logic [1:0]                    aw_burst;
    logic [C_NASTI_USER_WIDTH-1:0] aw_user;
  } aw_trans;

  typedef struct packed {
    logic [C_NASTI_DATA_WIDTH-1:0] w_data;
    logic [C_NASTI_STRB_WIDTH-1:0] w_strb;
    logic                          w_last;
    logic [C_NASTI_USER_WIDTH-1:0] w_user;
  } w_trans;

  typedef struct packed {
    logic [C_NASTI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                    b_resp;
    logic [C_NASTI_USER_WIDTH-1:0] b_user;
  } b_trans;

endpackage

// File: rtl/nasti_addr_gen.sv
// Next-beat address generator for NASTI bursts (purely combinational).
// Ports:
//   addr_i      current beat byte address
//   size_i      log2 of bytes per beat
//   len_i       burst length minus one
//   burst_i     burst type (FIXED / INCR / WRAP, reserved treated as INCR)
//   next_addr_o address of the following beat
module nasti_addr_gen
  import nasti_mc_pkg::*;
(
  input  logic [C_NASTI_ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]                    size_i,
  input  logic [7:0]                    len_i,
  input  logic [1:0]                    burst_i,
  output logic [C_NASTI_ADDR_WIDTH-1:0] next_addr_o
);

  localparam int unsigned AW = C_NASTI_ADDR_WIDTH;

  logic [AW-1:0] inc;
  logic [AW-1:0] wrap_mask;

  always_comb begin
    inc       = AW'(1) << size_i;
    // Wrap window is the whole burst footprint: (len+1) beats of 2^size bytes.
    wrap_mask = ((AW'(len_i) + AW'(1)) << size_i) - AW'(1);
    unique case (burst_i)
      BurstFixed: next_addr_o = addr_i;
      BurstWrap:  next_addr_o = (addr_i & ~wrap_mask) | ((addr_i + inc) & wrap_mask);
      // INCR and the reserved encoding: align down, then step; wraps through 0.
      default:    next_addr_o = (addr_i & ~(inc - AW'(1))) + inc;
    endcase
  end

endmodule

// File: rtl/nasti_burst_splitter.sv
// Core-clock burst splitter. Pops AR/AW/W FIFO heads, arbitrates reads against
// writes per burst (alternating on contention), expands each burst into
// per-beat commands for the DDR scheduler and pushes one B response per write.
// Ports:
//   core_clk, core_arstn            clock, synchronous active-low reset
//   rdata_ar/rempty_ar/rinc_ar      AR FIFO head, empty, pop
//   rdata_aw/rempty_aw/rinc_aw      AW FIFO head, empty, pop
//   rdata_w/rempty_w/rinc_w         W FIFO head, empty, pop
//   wdata_b/wfull_b/winc_b          B FIFO data, full, push
//   cmd_*                           beat command valid/ready handshake + fields
// Optional feature macro: NASTI_WLAST_CHECK_EN (w_last vs beat count -> SLVERR).
module nasti_burst_splitter
  import nasti_mc_pkg::*;
(
  input  logic                          core_clk,
  input  logic                          core_arstn,
  input  ar_trans                       rdata_ar,
  input  logic                          rempty_ar,
  output logic                          rinc_ar,
  input  aw_trans                       rdata_aw,
  input  logic                          rempty_aw,
  output logic                          rinc_aw,
  input  w_trans                        rdata_w,
  input  logic                          rempty_w,
  output logic                          rinc_w,
  output b_trans                        wdata_b,
  input  logic                          wfull_b,
  output logic                          winc_b,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic                          cmd_we,
  output logic [C_NASTI_ADDR_WIDTH-1:0] cmd_addr,
  output logic [C_NASTI_ID_WIDTH-1:0]   cmd_id,
  output logic                          cmd_last,
  output logic [C_NASTI_DATA_WIDTH-1:0] cmd_wdata,
  output logic [C_NASTI_STRB_WIDTH-1:0] cmd_wstrb
);

  state_e                        state_q, state_d;
  logic                          prio_q, prio_d;  // 0: read wins next tie, 1: write
  logic [7:0]                    beat_q, beat_d;
  logic [7:0]                    len_q, len_d;
  logic [C_NASTI_ID_WIDTH-1:0]   id_q, id_d;
  logic [C_NASTI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]                    size_q, size_d;
  logic [1:0]                    burst_q, burst_d;
  logic [C_NASTI_USER_WIDTH-1:0] user_q, user_d;

  logic [C_NASTI_ADDR_WIDTH-1:0] addr_next;
  logic                          arb_en, grant_rd, grant_wr, is_last, beat_acc;
  logic [1:0]                    resp;

  nasti_addr_gen u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (addr_next)
  );

  // No grant while reset is held, so nothing is popped and then dropped.
  assign arb_en   = (state_q == StIdle) && core_arstn;
  assign grant_rd = arb_en && !rempty_ar && (rempty_aw || !prio_q);
  assign grant_wr = arb_en && !rempty_aw && (rempty_ar || prio_q);
  assign is_last  = (beat_q == len_q);
  assign beat_acc = cmd_valid && cmd_ready;

`ifdef NASTI_WLAST_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (grant_wr) begin
      err_d = 1'b0;
    end else if ((state_q == StWrBurst) && beat_acc && (rdata_w.w_last != is_last)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge core_clk) begin
    if (!core_arstn) err_q <= 1'b0;
    else             err_q <= err_d;
  end

  assign resp = err_q ? RespSlverr : RespOkay;
`else
  assign resp = RespOkay;
`endif

  always_ff @(posedge core_clk) begin
    if (!core_arstn) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      beat_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      user_q  <= user_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    beat_d  = beat_q;
    len_d   = len_q;
    id_d    = id_q;
    addr_d  = addr_q;
    size_d  = size_q;
    burst_d = burst_q;
    user_d  = user_q;
    unique case (state_q)
      StIdle: begin
        if (grant_rd) begin
          id_d    = rdata_ar.ar_id;
          addr_d  = rdata_ar.ar_addr;
          len_d   = rdata_ar.ar_len;
          size_d  = rdata_ar.ar_size;
          burst_d = rdata_ar.ar_burst;
          user_d  = rdata_ar.ar_user;
          beat_d  = '0;
          state_d = StRdBurst;
          if (!rempty_aw) prio_d = 1'b1;
        end else if (grant_wr) begin
          id_d    = rdata_aw.aw_id;
          addr_d  = rdata_aw.aw_addr;
          len_d   = rdata_aw.aw_len;
          size_d  = rdata_aw.aw_size;
          burst_d = rdata_aw.aw_burst;
          user_d  = rdata_aw.aw_user;
          beat_d  = '0;
          state_d = StWrBurst;
          if (!rempty_ar) prio_d = 1'b0;
        end
      end
      StRdBurst, StWrBurst: begin
        if (beat_acc) begin
          beat_d = beat_q + 8'd1;
          addr_d = addr_next;
          if (is_last) state_d = (state_q == StRdBurst) ? StIdle : StWrResp;
        end
      end
      StWrResp: begin
        if (!wfull_b) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rinc_ar   = grant_rd;
    rinc_aw   = grant_wr;
    rinc_w    = 1'b0;
    winc_b    = 1'b0;
    wdata_b   = '0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_last  = 1'b0;
    cmd_addr  = addr_q;
    cmd_id    = id_q;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    unique case (state_q)
      StRdBurst: begin
        cmd_valid = 1'b1;
        cmd_last  = is_last;
      end
      StWrBurst: begin
        cmd_valid = !rempty_w;
        cmd_we    = 1'b1;
        cmd_last  = is_last;
        cmd_wdata = rdata_w.w_data;
        cmd_wstrb = rdata_w.w_strb;
        rinc_w    = !rempty_w && cmd_ready;
      end
      StWrResp: begin
        winc_b         = !wfull_b;
        wdata_b.b_id   = id_q;
        wdata_b.b_resp = resp;
        wdata_b.b_user = user_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nasti_burst_splitter.sv
module tb_nasti_burst_splitter;
  import nasti_mc_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [8:0]  id;
    logic        last;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } beat_t;

  logic        core_clk = 1'b0;
  logic        core_arstn = 1'b0;
  ar_trans     rdata_ar;
  logic        rempty_ar;
  logic        rinc_ar;
  aw_trans     rdata_aw;
  logic        rempty_aw;
  logic        rinc_aw;
  w_trans      rdata_w;
  logic        rempty_w;
  logic        rinc_w;
  b_trans      wdata_b;
  logic        wfull_b;
  logic        winc_b;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [8:0]  cmd_id;
  logic        cmd_last;
  logic [63:0] cmd_wdata;
  logic [7:0]  cmd_wstrb;

  always #5 core_clk = ~core_clk;

  nasti_burst_splitter dut (
    .core_clk   (core_clk),
    .core_arstn (core_arstn),
    .rdata_ar   (rdata_ar),
    .rempty_ar  (rempty_ar),
    .rinc_ar    (rinc_ar),
    .rdata_aw   (rdata_aw),
    .rempty_aw  (rempty_aw),
    .rinc_aw    (rinc_aw),
    .rdata_w    (rdata_w),
    .rempty_w   (rempty_w),
    .rinc_w     (rinc_w),
    .wdata_b    (wdata_b),
    .wfull_b    (wfull_b),
    .winc_b     (winc_b),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_id     (cmd_id),
    .cmd_last   (cmd_last),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb)
  );

  // Bench-side FIFOs feeding the DUT, and the expected-output scoreboards.
  ar_trans ar_q[$];
  aw_trans aw_q[$];
  w_trans  w_q[$];
  w_trans  wm[$];
  int      w_vis;
  beat_t   exp_cmd[$];
  b_trans  exp_b[$];

  int n_vec = 0;
  int n_err = 0;
  int ready_pct, bfull_pct, warr_pct;
  bit chk_no_valid, chk_no_binc;
  bit p_valid, p_ready, p_rinc_ar, p_rinc_aw, p_rst_low;
  beat_t p_cmd;
  int n_wacc, n_rinc_ar, n_rinc_w, n_winc_b, n_cyc, first_acc, last_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    rempty_ar = (ar_q.size() == 0);
    rdata_ar  = rempty_ar ? '0 : ar_q[0];
    rempty_aw = (aw_q.size() == 0);
    rdata_aw  = rempty_aw ? '0 : aw_q[0];
    rempty_w  = (w_vis == 0);
    rdata_w   = rempty_w ? '0 : w_q[0];
  endtask

  task automatic do_checks();
    beat_t e;
    bit    acc;
    acc = cmd_valid && cmd_ready;
    if (!core_arstn) begin
      if (p_rst_low) begin
        check("rst_ctrl_outputs", 64'({rinc_ar, rinc_aw, rinc_w, winc_b, cmd_valid, cmd_we,
                                        cmd_last}), 64'd0);
        check("rst_wdata_b", 64'(wdata_b), 64'd0);
      end
      p_valid = 1'b0; p_rinc_ar = 1'b0; p_rinc_aw = 1'b0;
    end else begin
      if (p_rinc_ar) check("rd_first_valid", 64'({cmd_valid, cmd_we}), 64'd2);
      if (p_rinc_aw) check("wr_state_we", 64'(cmd_we), 64'd1);
      if (p_valid && !p_ready) begin
        check("hold_valid", 64'(cmd_valid), 64'd1);
        check("hold_addr", 64'(cmd_addr), 64'(p_cmd.addr));
        check("hold_id_last_we", 64'({cmd_id, cmd_last, cmd_we}),
              64'({p_cmd.id, p_cmd.last, p_cmd.we}));
      end
      if (rinc_ar) check("rinc_ar_when_empty", 64'(rempty_ar), 64'd0);
      if (rinc_aw) check("rinc_aw_when_empty", 64'(rempty_aw), 64'd0);
      check("rinc_w_vs_accept", 64'(rinc_w), 64'(acc && cmd_we));
      if (acc) begin
        check("beat_expected", 64'(exp_cmd.size() > 0), 64'd1);
        if (exp_cmd.size() > 0) begin
          e = exp_cmd.pop_front();
          check("beat_we", 64'(cmd_we), 64'(e.we));
          check("beat_addr", 64'(cmd_addr), 64'(e.addr));
          check("beat_id", 64'(cmd_id), 64'(e.id));
          check("beat_last", 64'(cmd_last), 64'(e.last));
          check("beat_wstrb", 64'(cmd_wstrb), 64'(e.wstrb));
          if (e.we) check("beat_wdata", cmd_wdata, e.wdata);
        end
        if (cmd_we) n_wacc++;
        if (first_acc < 0) first_acc = n_cyc;
        last_acc = n_cyc;
      end
      if (winc_b) begin
        n_winc_b++;
        check("winc_b_when_full", 64'(wfull_b), 64'd0);
        check("b_expected", 64'(exp_b.size() > 0), 64'd1);
        if (exp_b.size() > 0) begin
          check("b_trans", 64'(wdata_b), 64'(exp_b.pop_front()));
        end
      end
      if (chk_no_valid) check("stall_no_valid", 64'(cmd_valid), 64'd0);
      if (chk_no_binc) check("no_winc_b", 64'(winc_b), 64'd0);
      n_rinc_ar += int'(rinc_ar);
      n_rinc_w  += int'(rinc_w);
      p_valid   = cmd_valid;
      p_rinc_ar = rinc_ar;
      p_rinc_aw = rinc_aw;
    end
    p_ready   = cmd_ready;
    p_cmd     = '{cmd_we, cmd_addr, cmd_id, cmd_last, cmd_wdata, cmd_wstrb};
    p_rst_low = !core_arstn;
  endtask

  task automatic cycle();
    bit pop_ar, pop_aw, pop_w;
    @(negedge core_clk);
    do_checks();
    pop_ar = rinc_ar; pop_aw = rinc_aw; pop_w = rinc_w;
    @(posedge core_clk);
    #1;
    n_cyc++;
    if (pop_ar && ar_q.size() > 0) void'(ar_q.pop_front());
    if (pop_aw && aw_q.size() > 0) void'(aw_q.pop_front());
    if (pop_w && w_vis > 0) begin
      void'(w_q.pop_front());
      w_vis--;
    end
    if (w_vis < w_q.size() && $urandom_range(99) < warr_pct) w_vis++;
    cmd_ready = ($urandom_range(99) < ready_pct);
    wfull_b   = ($urandom_range(99) < bfull_pct);
    drive_inputs();
  endtask

  // Reference: closed-form beat address from the burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] a0, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input int k);
    longint unsigned inc, total, base;
    inc   = 64'd1 << size;
    total = (longint'(len) + 1) * inc;
    if (k == 0 || burst == 2'b00) return a0;
    if (burst == 2'b10) begin
      base = longint'(a0) - (longint'(a0) % total);
      return 32'(base + ((longint'(a0) + longint'(k) * inc) % total));
    end
    return 32'((longint'(a0) / inc) * inc + longint'(k) * inc);
  endfunction

  task automatic expand(input bit we, input logic [8:0] id, input logic [31:0] a0,
                        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                        input logic user, inout int wi);
    beat_t  b;
    b_trans r;
    bit     err;
    err = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      b.we   = we;
      b.addr = beat_addr(a0, len, size, burst, k);
      b.id   = id;
      b.last = (k == int'(len));
      b.wdata = '0;
      b.wstrb = '0;
      if (we) begin
        b.wdata = wm[wi].w_data;
        b.wstrb = wm[wi].w_strb;
        if (wm[wi].w_last != b.last) err = 1'b1;
        wi++;
      end
      exp_cmd.push_back(b);
    end
    if (we) begin
      r.b_id = id;
      r.b_user = user;
`ifdef NASTI_WLAST_CHECK_EN
      r.b_resp = err ? 2'b10 : 2'b00;
`else
      r.b_resp = 2'b00;
`endif
      exp_b.push_back(r);
    end
  endtask

  // Grant order: lone requester wins; on a tie the priority side wins and flips.
  task automatic build_model();
    ar_trans ra[$];
    aw_trans wa[$];
    ar_trans a;
    aw_trans w;
    int      wi;
    bit      prio, pick_w;
    ra = ar_q; wa = aw_q; wm = w_q; wi = 0; prio = 1'b0;
    while (ra.size() > 0 || wa.size() > 0) begin
      if (ra.size() > 0 && wa.size() > 0) begin
        pick_w = prio;
        prio   = !prio;
      end else begin
        pick_w = (wa.size() > 0);
      end
      if (!pick_w) begin
        a = ra.pop_front();
        expand(1'b0, a.ar_id, a.ar_addr, a.ar_len, a.ar_size, a.ar_burst, a.ar_user, wi);
      end else begin
        w = wa.pop_front();
        expand(1'b1, w.aw_id, w.aw_addr, w.aw_len, w.aw_size, w.aw_burst, w.aw_user, wi);
      end
    end
  endtask

  task automatic reset_dut();
    core_arstn = 1'b0;
    ar_q.delete(); aw_q.delete(); w_q.delete(); w_vis = 0;
    exp_cmd.delete(); exp_b.delete();
    drive_inputs();
    repeat (3) cycle();
    n_wacc = 0; n_rinc_ar = 0; n_rinc_w = 0; n_winc_b = 0; first_acc = -1; last_acc = -1;
  endtask

  task automatic start();
    build_model();
    core_arstn = 1'b1;
    drive_inputs();
  endtask

  task automatic run_to_done(input string tag);
    int n;
    n = 0;
    while ((exp_cmd.size() + exp_b.size() + ar_q.size() + aw_q.size()) > 0 && n < 3000) begin
      cycle();
      n++;
    end
    check({tag, "_complete"}, 64'(exp_cmd.size() + exp_b.size() + ar_q.size() + aw_q.size()),
          64'd0);
    repeat (3) cycle();
  endtask

  function automatic ar_trans mk_ar(input logic [8:0] id, input logic [31:0] a,
                                    input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst);
    return '{ar_id: id, ar_addr: a, ar_len: len, ar_size: size, ar_burst: burst, ar_user: 1'b0};
  endfunction

  function automatic aw_trans mk_aw(input logic [8:0] id, input logic [31:0] a,
                                    input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst, input logic user);
    return '{aw_id: id, aw_addr: a, aw_len: len, aw_size: size, aw_burst: burst, aw_user: user};
  endfunction

  task automatic push_w(input int nbeats, input int bad_last);
    w_trans w;
    for (int k = 0; k < nbeats; k++) begin
      w.w_data = {$urandom, $urandom};
      w.w_strb = 8'($urandom);
      w.w_last = (k == nbeats - 1);
      if (k == bad_last) w.w_last = 1'b1;
      if (bad_last >= 0 && k == nbeats - 1) w.w_last = 1'b0;
      w.w_user = 1'b0;
      w_q.push_back(w);
    end
  endtask

  task automatic rand_burst(output logic [31:0] a, output logic [7:0] len,
                            output logic [2:0] size, output logic [1:0] burst);
    size  = 3'($urandom_range(3));
    burst = 2'($urandom_range(3));
    len   = 8'($urandom_range(7));
    if ($urandom_range(24) == 0) len = 8'($urandom_range(255));
    a = $urandom;
    if (burst == 2'b10) begin
      len = 8'((1 << $urandom_range(4, 1)) - 1);
      a   = a & ~((32'd1 << size) - 32'd1);
    end
    if ($urandom_range(7) == 0) a = 32'hFFFF_FFF0 | (a & 32'h0000_000F);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          n;
    cmd_ready = 1'b0; wfull_b = 1'b0;
    chk_no_valid = 1'b0; chk_no_binc = 1'b0;
    p_valid = 1'b0; p_ready = 1'b0; p_rinc_ar = 1'b0; p_rinc_aw = 1'b0; p_rst_low = 1'b0;
    n_cyc = 0;
    ready_pct = 100; bfull_pct = 0; warr_pct = 100;

    // INCR read: four back-to-back beats, single AR pop.
    reset_dut();
    ar_q.push_back(mk_ar(9'h011, 32'h0000_1000, 8'd3, 3'd3, 2'b01));
    start();
    run_to_done("incr_read");
    check("incr_read_rinc_ar", 64'(n_rinc_ar), 64'd1);
    check("incr_read_consecutive", 64'(last_acc - first_acc), 64'd3);

    // WRAP write with W preloaded.
    reset_dut();
    aw_q.push_back(mk_aw(9'h155, 32'h0000_1038, 8'd3, 3'd3, 2'b10, 1'b1));
    push_w(4, -1);
    w_vis = 4;
    start();
    run_to_done("wrap_write");
    check("wrap_write_rinc_w", 64'(n_rinc_w), 64'd4);
    check("wrap_write_winc_b", 64'(n_winc_b), 64'd1);

    // Contention from reset: R,W,R,W expected via model ids.
    reset_dut();
    ar_q.push_back(mk_ar(9'h001, 32'h100, 8'd0, 3'd3, 2'b01));
    ar_q.push_back(mk_ar(9'h002, 32'h200, 8'd0, 3'd3, 2'b01));
    aw_q.push_back(mk_aw(9'h003, 32'h300, 8'd0, 3'd3, 2'b01, 1'b0));
    aw_q.push_back(mk_aw(9'h004, 32'h400, 8'd0, 3'd3, 2'b01, 1'b0));
    push_w(1, -1);
    push_w(1, -1);
    w_vis = 2;
    start();
    run_to_done("arbitration");

    // W stall mid-burst, then B FIFO full.
    warr_pct = 0;
    reset_dut();
    aw_q.push_back(mk_aw(9'h007, 32'h2000, 8'd1, 3'd3, 2'b01, 1'b0));
    push_w(2, -1);
    w_vis = 1;
    start();
    n = 0;
    while (n_wacc < 1 && n < 50) begin cycle(); n++; end
    check("stall_first_beat", 64'(n_wacc), 64'd1);
    chk_no_valid = 1'b1;
    repeat (5) cycle();
    chk_no_valid = 1'b0;
    bfull_pct = 100;
    w_vis = 1;
    drive_inputs();
    cycle();
    chk_no_binc = 1'b1;
    repeat (3) cycle();
    chk_no_binc = 1'b0;
    bfull_pct = 0;
    wfull_b = 1'b0;
    warr_pct = 100;
    run_to_done("stall");
    check("stall_winc_b", 64'(n_winc_b), 64'd1);

    // INCR read wrapping through address zero.
    reset_dut();
    ar_q.push_back(mk_ar(9'h0A5, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01));
    start();
    run_to_done("addr_wrap");

    // Reset mid write burst: dropped, no B.
    reset_dut();
    aw_q.push_back(mk_aw(9'h0C3, 32'h3000, 8'd3, 3'd3, 2'b01, 1'b0));
    push_w(4, -1);
    w_vis = 4;
    start();
    n = 0;
    while (n_wacc < 1 && n < 50) begin cycle(); n++; end
    check("midburst_first_beat", 64'(n_wacc), 64'd1);
    core_arstn = 1'b0;
    ar_q.delete(); aw_q.delete(); w_q.delete(); w_vis = 0;
    exp_cmd.delete(); exp_b.delete();
    drive_inputs();
    repeat (3) cycle();
    core_arstn = 1'b1;
    chk_no_binc = 1'b1;
    repeat (10) cycle();
    chk_no_binc = 1'b0;

    // w_last asserted early on beat index 2 of a 4-beat write.
    reset_dut();
    aw_q.push_back(mk_aw(9'h0E1, 32'h4000, 8'd3, 3'd3, 2'b01, 1'b1));
    push_w(4, 2);
    w_vis = 4;
    start();
    run_to_done("wlast");
    check("wlast_beats", 64'(n_wacc), 64'd4);

    // Randomized scenarios.
    for (int s = 0; s < 40; s++) begin
      ready_pct = $urandom_range(100, 30);
      bfull_pct = $urandom_range(60);
      warr_pct  = $urandom_range(100, 30);
      reset_dut();
      for (int i = $urandom_range(4); i > 0; i--) begin
        rand_burst(a, len, size, burst);
        ar_q.push_back(mk_ar(9'($urandom), a, len, size, burst));
      end
      for (int i = $urandom_range(4); i > 0; i--) begin
        rand_burst(a, len, size, burst);
        aw_q.push_back(mk_aw(9'($urandom), a, len, size, burst, 1'($urandom)));
        push_w(int'(len) + 1, ($urandom_range(7) == 0) ? int'($urandom_range(int'(len))) : -1);
      end
      w_vis = $urandom_range(w_q.size());
      start();
      run_to_done("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
